// File: rtl/beidou_pkg.sv
// Shared constants and types for the BeiDou B1I transmit/receive blocks.
package beidou_pkg;

    localparam logic [10:0] G1_INIT = 11'b11010110101;
    localparam logic [10:0] G2_INIT = 11'b00001000101;

    // Feedback taps: G1 bits 10,9,8,7,6,0; G2 bits 10,9,8,7,4,3,2,1,0.
    localparam logic [10:0] G1_TAPS = 11'b11111000001;
    localparam logic [10:0] G2_TAPS = 11'b11110011111;

    localparam logic [1:0] IF_POS  = 2'b01;
    localparam logic [1:0] IF_ZERO = 2'b00;
    localparam logic [1:0] IF_NEG  = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/beidou_gold_code_gen.sv
// G1/G2 Gold code generator; load has priority over step and restores the INIT values.
module beidou_gold_code_gen
    import beidou_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic step,
    output logic code
);

    logic [10:0] g1_q, g1_d;
    logic [10:0] g2_q, g2_d;

    always_comb begin
        g1_d = g1_q;
        g2_d = g2_q;
        if (load) begin
            g1_d = G1_INIT;
            g2_d = G2_INIT;
        end else if (step) begin
            g1_d = {g1_q[9:0], ^(g1_q & G1_TAPS)};
            g2_d = {g2_q[9:0], ^(g2_q & G2_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g1_q <= G1_INIT;
            g2_q <= G2_INIT;
        end else begin
            g1_q <= g1_d;
            g2_q <= g2_d;
        end
    end

    assign code = g1_q[10] ^ g2_q[0] ^ g2_q[2];

endmodule

// File: rtl/beidou_b1i_modulator.sv
// B1I-style transmit path: spreads nav bits with the G1^G2 Gold code and BPSK-modulates them
// onto a 4-phase (+1,0,-1,0) carrier, producing one 2-bit signed IF sample per clk.
module beidou_b1i_modulator
    import beidou_pkg::*;
#(
    parameter int unsigned CLKS_PER_CHIP  = 3052,
    parameter int unsigned CHIPS_PER_CODE = 2046,
    parameter int unsigned CODES_PER_BIT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [1:0] if_out,
    output logic       chip_strobe,
    output logic       code_epoch,
    output logic       bit_epoch,
    output logic       underrun,
    output logic       active
);

    localparam int unsigned ClkW  = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
    localparam int unsigned ChipW = (CHIPS_PER_CODE > 1) ? $clog2(CHIPS_PER_CODE) : 1;
    localparam int unsigned CodeW = (CODES_PER_BIT > 1) ? $clog2(CODES_PER_BIT) : 1;

    localparam logic [ClkW-1:0]  ClkMax  = ClkW'(CLKS_PER_CHIP - 1);
    localparam logic [ChipW-1:0] ChipMax = ChipW'(CHIPS_PER_CODE - 1);
    localparam logic [CodeW-1:0] CodeMax = CodeW'(CODES_PER_BIT - 1);

    state_t           state_q, state_d;
    logic             hold_full_q, hold_full_d;
    logic             hold_reg_q, hold_reg_d;
    logic             cur_bit_q, cur_bit_d;
    logic [ClkW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [ChipW-1:0] chip_cnt_q, chip_cnt_d;
    logic [CodeW-1:0] code_cnt_q, code_cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       if_out_q, if_out_d;

    logic run, accept, start, cont, code, b;

    assign run         = (state_q == RUN);
    assign chip_strobe = run && (clk_cnt_q == ClkMax);
    assign code_epoch  = chip_strobe && (chip_cnt_q == ChipMax);
    assign bit_epoch   = code_epoch && (code_cnt_q == CodeMax);
    assign accept      = data_valid && !hold_full_q;
    assign start       = !run && en && hold_full_q;
    assign cont        = bit_epoch && en && hold_full_q;
    assign underrun    = bit_epoch && en && !hold_full_q;
    assign b           = cur_bit_q ^ code;

    beidou_gold_code_gen u_gold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start || code_epoch),
        .step  (chip_strobe),
        .code  (code)
    );

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_reg_d  = hold_reg_q;
        cur_bit_d   = cur_bit_q;
        clk_cnt_d   = clk_cnt_q;
        chip_cnt_d  = chip_cnt_q;
        code_cnt_d  = code_cnt_q;
        phase_d     = phase_q;
        if_out_d    = IF_ZERO;

        if (accept) begin
            hold_reg_d  = data_in;
            hold_full_d = 1'b1;
        end
        if (start || cont) begin
            cur_bit_d   = hold_reg_q;
            hold_full_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    clk_cnt_d  = '0;
                    chip_cnt_d = '0;
                    code_cnt_d = '0;
                    phase_d    = 2'd0;
                end
            end
            RUN: begin
                unique case (phase_q)
                    2'd0:    if_out_d = b ? IF_POS : IF_NEG;
                    2'd2:    if_out_d = b ? IF_NEG : IF_POS;
                    default: if_out_d = IF_ZERO;
                endcase
                phase_d = phase_q + 2'd1;
                // Nested wrap: each counter only moves when every inner counter is at max.
                if (chip_strobe) begin
                    clk_cnt_d = '0;
                    if (code_epoch) begin
                        chip_cnt_d = '0;
                        code_cnt_d = bit_epoch ? '0 : code_cnt_q + CodeW'(1);
                    end else begin
                        chip_cnt_d = chip_cnt_q + ChipW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + ClkW'(1);
                end
                if (bit_epoch && !cont) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_reg_q  <= 1'b0;
            cur_bit_q   <= 1'b0;
            clk_cnt_q   <= '0;
            chip_cnt_q  <= '0;
            code_cnt_q  <= '0;
            phase_q     <= 2'd0;
            if_out_q    <= IF_ZERO;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_reg_q  <= hold_reg_d;
            cur_bit_q   <= cur_bit_d;
            clk_cnt_q   <= clk_cnt_d;
            chip_cnt_q  <= chip_cnt_d;
            code_cnt_q  <= code_cnt_d;
            phase_q     <= phase_d;
            if_out_q    <= if_out_d;
        end
    end

    assign data_ready = !hold_full_q;
    assign if_out     = if_out_q;
    assign active     = run;

endmodule
